elevador_multi: RTL and testbench

ELEVADOR_MULTI -- requirements
Module: elevador_multi

---
 rtl/elevador_multi.sv | 214 +++++++++++++++++++++
 tb/tb_elevador_multi.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/elevador_multi.sv
// -----------------------------------------------------------------------------
// elevador_multi
//
// Single-car elevator that loads passengers at floor 0, climbs and stops at
// every floor where someone on board wants to leave, then returns empty to
// floor 0 to load again. One counter per floor tracks how many passengers on
// board are bound for that floor. The door stays open for one tick per
// passenger leaving.
//
// Parameters
//   NFLOORS  number of floors (0..NFLOORS-1), >= 2
//   CAP      maximum passengers on board, >= 1
//   WAIT     ticks a partially loaded car waits at floor 0 before leaving
//   TRAVEL   ticks needed to move one floor
//
// Ports
//   clk_2     in   system clock, rising edge
//   reset     in   synchronous, active-high, overrides tick
//   tick      in   advance enable; everything holds while low
//   pessoa    in   a passenger boards at floor 0 on this tick
//   destino   in   [FW]  destination floor of that passenger
//   andar     out  [FW]  current floor
//   porta     out  door open
//   ocupacao  out  [CW]  passengers on board
//   estado    out  [2]   CARREGA=0, SOBE=1, DESEMBARQUE=2, DESCE=3
// -----------------------------------------------------------------------------
module elevador_multi #(
    parameter int NFLOORS = 4,
    parameter int CAP     = 2,
    parameter int WAIT    = 2,
    parameter int TRAVEL  = 2,
    parameter int FW      = $clog2(NFLOORS),
    parameter int CW      = $clog2(CAP + 1)
) (
    input  logic          clk_2,
    input  logic          reset,
    input  logic          tick,
    input  logic          pessoa,
    input  logic [FW-1:0] destino,
    output logic [FW-1:0] andar,
    output logic          porta,
    output logic [CW-1:0] ocupacao,
    output logic [1:0]    estado
);

    localparam int EW = $clog2(WAIT + 1);
    localparam int TW = $clog2(TRAVEL + 1);

    localparam logic [FW-1:0] TOP_FLOOR   = FW'(NFLOORS - 1);
    localparam logic [CW-1:0] CAP_C       = CW'(CAP);
    localparam logic [EW-1:0] WAIT_C      = EW'(WAIT);
    localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL - 1);

    typedef enum logic [1:0] {
        CARREGA     = 2'd0,
        SOBE        = 2'd1,
        DESEMBARQUE = 2'd2,
        DESCE       = 2'd3
    } estado_t;

    estado_t       estado_q, estado_d;
    logic [FW-1:0] andar_q, andar_d;
    logic          porta_q, porta_d;
    logic [CW-1:0] ocupacao_q, ocupacao_d;
    logic [EW-1:0] espera_q, espera_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [CW-1:0] cnt_q [NFLOORS];
    logic [CW-1:0] cnt_d [NFLOORS];

    logic          dest_in_range;
    logic          boarding_ok;
    logic [FW-1:0] andar_up;

    // When NFLOORS is a power of two every encodable destination is a real
    // floor, so the upper-bound check disappears at elaboration.
    if (NFLOORS == (1 << FW)) begin : g_dest_full
        assign dest_in_range = 1'b1;
    end else begin : g_dest_part
        assign dest_in_range = (destino <= TOP_FLOOR);
    end

    // Floor 0 is never a destination: nobody boards to stay where they are.
    assign boarding_ok = pessoa && (destino != '0) && dest_in_range
                         && (ocupacao_q < CAP_C);
    assign andar_up    = andar_q + 1'b1;

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a hold value first so no path through
        // the case statement can leave one unassigned and infer a latch.
        estado_d   = estado_q;
        andar_d    = andar_q;
        porta_d    = porta_q;
        ocupacao_d = ocupacao_q;
        espera_d   = espera_q;
        timer_d    = timer_q;
        cnt_d      = cnt_q;

        case (estado_q)
            CARREGA: begin
                porta_d = 1'b1;
                andar_d = '0;
                if ((ocupacao_q == CAP_C) ||
                    ((ocupacao_q != '0) && (espera_q == WAIT_C))) begin
                    // Departure edge: any boarding attempt is dropped.
                    estado_d = SOBE;
                    porta_d  = 1'b0;
                    espera_d = '0;
                    timer_d  = '0;
                end else begin
                    if (ocupacao_q != '0) begin
                        espera_d = espera_q + 1'b1;
                    end
                    if (boarding_ok) begin
                        ocupacao_d       = ocupacao_q + 1'b1;
                        cnt_d[destino]   = cnt_q[destino] + 1'b1;
                    end
                end
            end

            SOBE: begin
                porta_d = 1'b0;
                if (timer_q == TRAVEL_LAST) begin
                    timer_d = '0;
                    if (andar_q == TOP_FLOOR) begin
                        // Unreachable with consistent counters; keeps the car
                        // from ever climbing past the top floor.
                        estado_d = DESCE;
                    end else begin
                        andar_d = andar_up;
                        if (cnt_q[andar_up] != '0) begin
                            estado_d = DESEMBARQUE;
                            porta_d  = 1'b1;
                        end
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            DESEMBARQUE: begin
                porta_d = 1'b1;
                if (cnt_q[andar_q] != '0) begin
                    cnt_d[andar_q] = cnt_q[andar_q] - 1'b1;
                    if (ocupacao_q != '0) begin
                        ocupacao_d = ocupacao_q - 1'b1;
                    end
                end
                // Last passenger for this floor leaves on this tick.
                if (cnt_q[andar_q] <= CW'(1)) begin
                    porta_d  = 1'b0;
                    timer_d  = '0;
                    estado_d = (ocupacao_d == '0) ? DESCE : SOBE;
                end
            end

            DESCE: begin
                porta_d = 1'b0;
                if (timer_q == TRAVEL_LAST) begin
                    timer_d = '0;
                    if (andar_q <= FW'(1)) begin
                        andar_d  = '0;
                        estado_d = CARREGA;
                        porta_d  = 1'b1;
                        espera_d = '0;
                    end else begin
                        andar_d = andar_q - 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            default: estado_d = CARREGA;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_2) begin
        // NOTE: non-blocking assignments so every register samples the
        // values from before this edge, regardless of statement order.
        if (reset) begin
            estado_q   <= CARREGA;
            andar_q    <= '0;
            porta_q    <= 1'b1;
            ocupacao_q <= '0;
            espera_q   <= '0;
            timer_q    <= '0;
            // NOTE: the per-floor counters are flops, not a RAM, and must be
            // cleared here because reset discards everyone on board.
            for (int f = 0; f < NFLOORS; f++) begin
                cnt_q[f] <= '0;
            end
        end else if (tick) begin
            estado_q   <= estado_d;
            andar_q    <= andar_d;
            porta_q    <= porta_d;
            ocupacao_q <= ocupacao_d;
            espera_q   <= espera_d;
            timer_q    <= timer_d;
            cnt_q      <= cnt_d;
        end
    end

    assign andar    = andar_q;
    assign porta    = porta_q;
    assign ocupacao = ocupacao_q;
    assign estado   = estado_q;

endmodule

// File: tb/tb_elevador_multi.sv
// -----------------------------------------------------------------------------
// tb_elevador_multi
//
// Directed bench for elevador_multi. Two instances share the same stimulus:
// dut uses the default parameters, dut_w raises WAIT to 5 for the rejection and
// tick-freeze scenario. Inputs change and outputs are sampled on the falling
// edge; the design acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_elevador_multi;

    logic       clk_2 = 1'b0;
    logic       reset;
    logic       tick;
    logic       pessoa;
    logic [1:0] destino;

    logic [1:0] andar,   andar_w;
    logic       porta,   porta_w;
    logic [1:0] ocupacao, ocupacao_w;
    logic [1:0] estado,  estado_w;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_2 = ~clk_2;

    elevador_multi dut (
        .clk_2    (clk_2),
        .reset    (reset),
        .tick     (tick),
        .pessoa   (pessoa),
        .destino  (destino),
        .andar    (andar),
        .porta    (porta),
        .ocupacao (ocupacao),
        .estado   (estado)
    );

    elevador_multi #(.WAIT(5)) dut_w (
        .clk_2    (clk_2),
        .reset    (reset),
        .tick     (tick),
        .pessoa   (pessoa),
        .destino  (destino),
        .andar    (andar_w),
        .porta    (porta_w),
        .ocupacao (ocupacao_w),
        .estado   (estado_w)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges and come back to the falling edge.
    task automatic edges(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_2);
            @(negedge clk_2);
        end
    endtask

    task automatic exp_d(input string tag, input int a, input int p,
                         input int o, input int e);
        check({tag, "/andar"},    int'(andar),    a);
        check({tag, "/porta"},    int'(porta),    p);
        check({tag, "/ocupacao"}, int'(ocupacao), o);
        check({tag, "/estado"},   int'(estado),   e);
    endtask

    task automatic exp_w(input string tag, input int a, input int p,
                         input int o, input int e);
        check({tag, "/andar"},    int'(andar_w),    a);
        check({tag, "/porta"},    int'(porta_w),    p);
        check({tag, "/ocupacao"}, int'(ocupacao_w), o);
        check({tag, "/estado"},   int'(estado_w),   e);
    endtask

    task automatic board(input logic [1:0] d);
        pessoa  = 1'b1;
        destino = d;
        edges(1);
        pessoa  = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        tick    = 1'b1;
        pessoa  = 1'b0;
        destino = '0;

        // Reset state
        edges(1);
        exp_d("rst", 0, 1, 0, 0);
        exp_w("rst_w", 0, 1, 0, 0);
        reset = 1'b0;

        // Two passengers for floor 3: full car leaves at once
        board(2'd3);
        exp_d("a_b1", 0, 1, 1, 0);
        board(2'd3);
        exp_d("a_b2", 0, 1, 2, 0);
        edges(1);
        exp_d("a_dep", 0, 0, 2, 1);
        edges(5);
        exp_d("a_f2", 2, 0, 2, 1);
        edges(1);
        exp_d("a_f3", 3, 1, 2, 2);
        edges(1);
        exp_d("a_un1", 3, 1, 1, 2);
        edges(1);
        exp_d("a_un2", 3, 0, 0, 3);
        edges(5);
        exp_d("a_dn1", 1, 0, 0, 3);
        edges(1);
        exp_d("a_home", 0, 1, 0, 0);

        // One passenger for floor 1: waits WAIT ticks, then leaves
        board(2'd1);
        exp_d("b_b1", 0, 1, 1, 0);
        edges(2);
        exp_d("b_wait", 0, 1, 1, 0);
        edges(1);
        exp_d("b_dep", 0, 0, 1, 1);
        edges(2);
        exp_d("b_f1", 1, 1, 1, 2);
        edges(1);
        exp_d("b_un", 1, 0, 0, 3);
        edges(2);
        exp_d("b_home", 0, 1, 0, 0);

        // Destinations 1 and 3: stop at floor 1, resume, stop at floor 3
        board(2'd1);
        board(2'd3);
        exp_d("c_b2", 0, 1, 2, 0);
        edges(1);
        exp_d("c_dep", 0, 0, 2, 1);
        edges(2);
        exp_d("c_f1", 1, 1, 2, 2);
        edges(1);
        exp_d("c_res", 1, 0, 1, 1);
        edges(4);
        exp_d("c_f3", 3, 1, 1, 2);
        edges(1);
        exp_d("c_un", 3, 0, 0, 3);
        edges(6);
        exp_d("c_home", 0, 1, 0, 0);

        // Reset during SOBE at floor 2, with tick low
        board(2'd3);
        board(2'd3);
        edges(5);
        exp_d("d_f2", 2, 0, 2, 1);
        reset = 1'b1;
        tick  = 1'b0;
        edges(1);
        exp_d("d_rst", 0, 1, 0, 0);
        exp_w("d_rst_w", 0, 1, 0, 0);
        reset = 1'b0;
        tick  = 1'b1;
        edges(1);
        exp_d("d_empty", 0, 1, 0, 0);

        // WAIT=5 instance: reject floor 0, reject 3rd passenger, tick freeze
        board(2'd0);
        exp_w("e_d0", 0, 1, 0, 0);
        board(2'd2);
        exp_w("e_b1", 0, 1, 1, 0);
        board(2'd2);
        exp_w("e_b2", 0, 1, 2, 0);
        board(2'd1);
        exp_w("e_b3", 0, 0, 2, 1);
        edges(2);
        exp_w("e_f1", 1, 0, 2, 1);
        tick = 1'b0;
        for (int i = 0; i < 5; i++) begin
            edges(1);
            exp_w($sformatf("e_frz%0d", i), 1, 0, 2, 1);
        end
        tick = 1'b1;
        edges(1);
        exp_w("e_run", 1, 0, 2, 1);
        edges(1);
        exp_w("e_f2", 2, 1, 2, 2);
        edges(1);
        exp_w("e_un1", 2, 1, 1, 2);
        edges(1);
        exp_w("e_un2", 2, 0, 0, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
